// File: rtl/microc_pkg.sv
// Shared constants for the microcontroller core: instruction layout and ALU op codes.
// Return-stack support is built only when MICROC_STACK_EN is defined.
package microc_pkg;
  localparam int INSTR_W = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 10;
  localparam int RA1_MSB = 11;
  localparam int RA1_LSB = 8;
  localparam int RA2_MSB = 7;
  localparam int RA2_LSB = 4;
  localparam int WA3_MSB = 3;
  localparam int WA3_LSB = 0;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 4;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_NOT  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_NEGA = 3'b110,
    OP_NEGB = 3'b111
  } alu_op_e;
endpackage

// File: rtl/microc_stack.sv
// Return-address LIFO. Push is ignored when full, pop when empty; dout shows the top entry.
module microc_stack #(
  parameter int PCW    = 10,
  parameter int SDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [PCW-1:0]            din,
  output logic [PCW-1:0]            dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(SDEPTH):0]   count
);
  localparam int CW = $clog2(SDEPTH) + 1;
  localparam int IW = $clog2(SDEPTH);

  logic [PCW-1:0] mem [SDEPTH];
  logic [IW-1:0]  top_idx;

  assign full    = (count == CW'(SDEPTH));
  assign empty   = (count == '0);
  assign top_idx = IW'(count - CW'(1));
  assign dout    = mem[top_idx];

  // Clearing the count is enough to discard the contents on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (push && !full)  count <= count + CW'(1);
    else if (pop && !empty)  count <= count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[count[IW-1:0]] <= din;
  end
endmodule

// File: rtl/microc_call.sv
// Single-cycle microcontroller datapath with subroutine call/return.
// Define MICROC_STACK_EN to build the return stack; otherwise s_call/s_ret are ignored.
module microc_call import microc_pkg::*; #(
  parameter int DW     = 8,
  parameter int PCW    = 10,
  parameter int SDEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INSTR_W-1:0]      instr,
  output logic [PCW-1:0]          iaddr,
  output logic [5:0]              Opcode,
  output logic                    z,
  input  logic                    s_inc,
  input  logic                    s_inm,
  input  logic                    we3,
  input  logic                    wez,
  input  logic [2:0]              Op,
  input  logic                    s_call,
  input  logic                    s_ret,
  output logic [$clog2(SDEPTH):0] sp,
  output logic                    stk_err
);
  logic [DW-1:0]  rf [16];
  logic [3:0]     ra1, ra2, wa3;
  logic [DW-1:0]  a, b, alu, wd3;
  logic [PCW-1:0] pc, pc_inc, pc_nxt, target;

  assign Opcode = instr[OPC_MSB:OPC_LSB];
  assign ra1    = instr[RA1_MSB:RA1_LSB];
  assign ra2    = instr[RA2_MSB:RA2_LSB];
  assign wa3    = instr[WA3_MSB:WA3_LSB];
  assign target = instr[PCW-1:0];
  assign iaddr  = pc;
  assign pc_inc = pc + PCW'(1);

  // r0 is hardwired to zero on read; writes to it are dropped below.
  assign a   = (ra1 == 4'd0) ? '0 : rf[ra1];
  assign b   = (ra2 == 4'd0) ? '0 : rf[ra2];
  assign wd3 = s_inm ? DW'(instr[IMM_MSB:IMM_LSB]) : alu;

  always_comb begin
    alu = a;
    case (alu_op_e'(Op))
      OP_PASS: alu = a;
      OP_NOT:  alu = ~a;
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_NEGA: alu = '0 - a;
      OP_NEGB: alu = '0 - b;
      default: alu = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we3 && wa3 != 4'd0) rf[wa3] <= wd3;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      z  <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (wez) z <= (alu == '0);
    end
  end

`ifdef MICROC_STACK_EN
  logic           push, pop, full, empty, err_set;
  logic [PCW-1:0] top;

  // Call wins over return, return over plain sequencing.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    pc_nxt  = s_inc ? pc_inc : target;
    if (s_call) begin
      pc_nxt  = target;
      push    = !full;
      err_set = full;
    end else if (s_ret) begin
      if (empty) begin
        pc_nxt  = pc_inc;
        err_set = 1'b1;
      end else begin
        pc_nxt = top;
        pop    = 1'b1;
      end
    end
  end

  microc_stack #(.PCW(PCW), .SDEPTH(SDEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (top),
    .full  (full),
    .empty (empty),
    .count (sp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       stk_err <= 1'b0;
    else if (err_set) stk_err <= 1'b1;
  end
`else
  logic unused_stack;
  assign unused_stack = s_call ^ s_ret;
  assign pc_nxt       = s_inc ? pc_inc : target;
  assign sp           = '0;
  assign stk_err      = 1'b0;
`endif
endmodule

// File: tb/tb_microc_call.sv
// Scoreboard bench for microc_call: a behavioural model queues expected state per cycle,
// the DUT state is sampled after each edge and compared; a second instance covers PCW=4/DW=16.
module tb_microc_call;
  localparam int DW = 8, PCW = 10, SDEPTH = 8, SPW = $clog2(SDEPTH) + 1;
`ifdef MICROC_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [15:0] instr;
  logic s_inc, s_inm, we3, wez, s_call, s_ret;
  logic [2:0] op;
  logic [PCW-1:0] iaddr;
  logic [5:0] opcode;
  logic z, stk_err;
  logic [SPW-1:0] sp;

  logic [15:0] instr2;
  logic s_inc2, s_inm2, we32, wez2;
  logic [2:0] op2;
  logic [3:0] iaddr2;
  logic [5:0] opcode2;
  logic z2, stk_err2;
  logic [1:0] sp2;

  int total = 0, bad = 0;

  typedef struct {
    logic [PCW-1:0] pc;
    logic           z;
    logic [SPW-1:0] sp;
    logic           err;
  } st_t;

  st_t exp_q[$];
  st_t act_q[$];

  logic [DW-1:0]  m_regs [16];
  logic [PCW-1:0] m_pc;
  logic           m_z, m_err;
  logic [PCW-1:0] m_stk[$];

  always #5 clk = ~clk;

  microc_call #(.DW(DW), .PCW(PCW), .SDEPTH(SDEPTH)) dut (
    .clk(clk), .reset(reset), .instr(instr), .iaddr(iaddr), .Opcode(opcode), .z(z),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(op),
    .s_call(s_call), .s_ret(s_ret), .sp(sp), .stk_err(stk_err)
  );

  microc_call #(.DW(16), .PCW(4), .SDEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .instr(instr2), .iaddr(iaddr2), .Opcode(opcode2), .z(z2),
    .s_inc(s_inc2), .s_inm(s_inm2), .we3(we32), .wez(wez2), .Op(op2),
    .s_call(1'b0), .s_ret(1'b0), .sp(sp2), .stk_err(stk_err2)
  );

  // Drive one instruction, advance the model, clock it, and record what the DUT shows.
  task automatic step(input logic [15:0] i, input logic inc, inm, w3, wz,
                      input logic [2:0] o, input logic call, ret);
    logic [DW-1:0]  a, b, r;
    logic [PCW-1:0] pc1;
    st_t e, s;
    instr = i; s_inc = inc; s_inm = inm; we3 = w3; wez = wz; op = o;
    s_call = call; s_ret = ret;
    a = (i[11:8] == 4'd0) ? '0 : m_regs[i[11:8]];
    b = (i[7:4]  == 4'd0) ? '0 : m_regs[i[7:4]];
    case (o)
      3'd0: r = a;
      3'd1: r = ~a;
      3'd2: r = a + b;
      3'd3: r = a - b;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = -a;
      default: r = -b;
    endcase
    pc1 = m_pc + 1'b1;
    if (wz) m_z = (r == '0);
    if (w3 && i[3:0] != 4'd0) m_regs[i[3:0]] = inm ? DW'(i[11:4]) : r;
    if (STK && call) begin
      if (m_stk.size() < SDEPTH) m_stk.push_back(pc1);
      else m_err = 1'b1;
      m_pc = i[PCW-1:0];
    end else if (STK && ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_err = 1'b1; m_pc = pc1; end
    end else begin
      m_pc = inc ? pc1 : i[PCW-1:0];
    end
    e.pc = m_pc; e.z = m_z; e.sp = SPW'(m_stk.size()); e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk); #1;
    s.pc = iaddr; s.z = z; s.sp = sp; s.err = stk_err;
    act_q.push_back(s);
  endtask

  task automatic model_reset();
    m_pc = '0; m_z = 1'b0; m_err = 1'b0;
    m_stk.delete(); exp_q.delete(); act_q.delete();
  endtask

  task automatic test_reset();
    total++;
    if ({iaddr, z, sp, stk_err} !== '0) begin
      bad++;
      $display("FAIL reset_state: iaddr=%0h z=%0b sp=%0d err=%0b, want all 0", iaddr, z, sp, stk_err);
    end
    total++;
    if (iaddr2 !== 4'd0 || z2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state2: iaddr2=%0h z2=%0b, want 0 0", iaddr2, z2);
    end
  endtask

  task automatic test_alu();
    logic [7:0] tbl [8];
    st_t e, s;
    tbl[0] = 8'h0C; tbl[1] = 8'hF3; tbl[2] = 8'h11; tbl[3] = 8'h07;
    tbl[4] = 8'h04; tbl[5] = 8'h0D; tbl[6] = 8'hF4; tbl[7] = 8'hFB;
    instr = 16'hA7FF; #1;
    total++;
    if (opcode !== 6'h29) begin
      bad++; $display("FAIL opcode: got %0h want 29", opcode);
    end
    step({4'h0, 8'h05, 4'h1}, 1, 1, 1, 0, 3'd0, 0, 0);        // r1 = 5
    step({4'h0, 4'h1, 4'h0, 4'h0}, 1, 0, 0, 1, 3'd0, 0, 0);   // z <- (r1 == 0)
    total++;
    if (z !== 1'b0) begin bad++; $display("FAIL r1_nonzero: z=%0b want 0", z); end
    step({4'h0, 4'h1, 4'h1, 4'h0}, 1, 0, 0, 1, 3'd3, 0, 0);   // r1 - r1
    total++;
    if (z !== 1'b1) begin bad++; $display("FAIL r1_sub_self: z=%0b want 1", z); end
    step({4'h0, 8'h0C, 4'h2}, 1, 1, 1, 0, 3'd0, 0, 0);        // r2 = 0x0C
    for (int k = 0; k < 8; k++) begin
      step({4'h0, 4'h2, 4'h1, 4'h6}, 1, 0, 1, 0, 3'(k), 0, 0); // r6 = r2 op r1
      step({4'h0, tbl[k], 4'h7}, 1, 1, 1, 0, 3'd0, 0, 0);      // r7 = expected
      step({4'h0, 4'h6, 4'h7, 4'h0}, 1, 0, 0, 1, 3'd3, 0, 0);  // z <- (r6 == r7)
      total++;
      if (z !== 1'b1) begin bad++; $display("FAIL alu_op%0d: z=%0b want 1", k, z); end
    end
    step({4'h0, 4'h1, 4'h0, 4'h0}, 1, 0, 0, 1, 3'd0, 0, 0);   // z = 0
    step({4'h0, 8'h33, 4'h0}, 1, 1, 1, 0, 3'd0, 0, 0);        // write to r0, dropped
    step({4'h0, 4'h0, 4'h0, 4'h0}, 1, 0, 0, 1, 3'd0, 0, 0);   // z <- (r0 == 0)
    total++;
    if (z !== 1'b1) begin bad++; $display("FAIL r0_zero: z=%0b want 1", z); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); s = act_q.pop_front(); total++;
      if (s !== e) begin
        bad++;
        $display("FAIL alu_model: pc=%0h z=%0b sp=%0d err=%0b want %0h %0b %0d %0b",
                 s.pc, s.z, s.sp, s.err, e.pc, e.z, e.sp, e.err);
      end
    end
  endtask

  task automatic test_reset_midrun();
    st_t e, s;
    instr = 16'h0077; s_inc = 0; s_call = 1; s_ret = 0; we3 = 0; wez = 0;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({iaddr, z, sp, stk_err} !== '0 || iaddr2 !== 4'd0) begin
      bad++;
      $display("FAIL async_reset: iaddr=%0h z=%0b sp=%0d err=%0b, want all 0", iaddr, z, sp, stk_err);
    end
    @(posedge clk); #1;
    s_call = 0; s_inc = 1; instr = 16'h0000;
    reset = 1'b1;
    model_reset();
    step(16'h0000, 1, 0, 0, 0, 3'd0, 0, 0);
    total++;
    if (iaddr !== 10'd1) begin bad++; $display("FAIL restart_pc: iaddr=%0h want 1", iaddr); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); s = act_q.pop_front(); total++;
      if (s !== e) begin
        bad++;
        $display("FAIL reset_model: pc=%0h z=%0b sp=%0d err=%0b want %0h %0b %0d %0b",
                 s.pc, s.z, s.sp, s.err, e.pc, e.z, e.sp, e.err);
      end
    end
  endtask

  task automatic test_call_ret();
    st_t e, s;
    while (m_pc != 10'd3) step(16'h0000, 1, 0, 0, 0, 3'd0, 0, 0);
    step(16'h0040, 0, 0, 0, 0, 3'd0, 1, 0);
    total++;
    if (iaddr !== 10'h040 || sp !== (STK ? 4'd1 : 4'd0)) begin
      bad++; $display("FAIL call: iaddr=%0h sp=%0d want 40 %0d", iaddr, sp, STK ? 1 : 0);
    end
    step(16'h0000, 1, 0, 0, 0, 3'd0, 0, 1);
    total++;
    if (iaddr !== (STK ? 10'h004 : 10'h041) || sp !== 4'd0) begin
      bad++; $display("FAIL ret: iaddr=%0h sp=%0d want %0h 0", iaddr, sp, STK ? 4 : 'h41);
    end
    step(16'h0000, 1, 0, 0, 0, 3'd0, 0, 0);
    step(16'h0000, 1, 0, 0, 0, 3'd0, 0, 0);
    step(16'h0000, 1, 0, 0, 0, 3'd0, 0, 0);
    if (STK) begin
      step(16'h0123, 0, 0, 0, 0, 3'd0, 0, 1);                  // return with empty stack at PC=7
      total++;
      if (iaddr !== 10'h008 || stk_err !== 1'b1 || sp !== 4'd0) begin
        bad++; $display("FAIL ret_empty: iaddr=%0h err=%0b sp=%0d want 8 1 0", iaddr, stk_err, sp);
      end
    end else begin
      step(16'h0123, 0, 0, 0, 0, 3'd0, 0, 1);
      total++;
      if (iaddr !== 10'h123 || stk_err !== 1'b0) begin
        bad++; $display("FAIL ret_ignored: iaddr=%0h err=%0b want 123 0", iaddr, stk_err);
      end
    end
    step(16'h0050, 1, 0, 0, 0, 3'd0, 1, 1);
    total++;
    if (iaddr !== (STK ? 10'h050 : 10'h124) || sp !== (STK ? 4'd1 : 4'd0)) begin
      bad++; $display("FAIL call_and_ret: iaddr=%0h sp=%0d", iaddr, sp);
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); s = act_q.pop_front(); total++;
      if (s !== e) begin
        bad++;
        $display("FAIL callret_model: pc=%0h z=%0b sp=%0d err=%0b want %0h %0b %0d %0b",
                 s.pc, s.z, s.sp, s.err, e.pc, e.z, e.sp, e.err);
      end
    end
  endtask

  task automatic test_nested();
    st_t e, s;
    for (int k = 0; k < 9; k++) begin
      step(16'h0100 + 16'(k * 16), 0, 0, 0, 0, 3'd0, 1, 0);
      if (k == 7) begin
        total++;
        if (stk_err !== 1'b0 || sp !== (STK ? 4'd8 : 4'd0)) begin
          bad++; $display("FAIL eighth_call: err=%0b sp=%0d", stk_err, sp);
        end
      end
    end
    total++;
    if (iaddr !== 10'h180 || sp !== (STK ? 4'd8 : 4'd0) || stk_err !== STK) begin
      bad++; $display("FAIL overflow: iaddr=%0h sp=%0d err=%0b want 180 %0d %0b", iaddr, sp, stk_err, STK ? 8 : 0, STK);
    end
    for (int k = 0; k < 8; k++) step(16'h0000, 1, 0, 0, 0, 3'd0, 0, 1);
    total++;
    if (iaddr !== (STK ? 10'h002 : 10'h188) || sp !== 4'd0 || stk_err !== STK) begin
      bad++; $display("FAIL unwind: iaddr=%0h sp=%0d err=%0b", iaddr, sp, stk_err);
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); s = act_q.pop_front(); total++;
      if (s !== e) begin
        bad++;
        $display("FAIL nested_model: pc=%0h z=%0b sp=%0d err=%0b want %0h %0b %0d %0b",
                 s.pc, s.z, s.sp, s.err, e.pc, e.z, e.sp, e.err);
      end
    end
  endtask

  task automatic test_wrap_wide();
    s_inc2 = 1; instr2 = 16'h0000;
    repeat (15) @(posedge clk);
    #1;
    total++;
    if (iaddr2 !== 4'hF) begin bad++; $display("FAIL pc_top: iaddr2=%0h want f", iaddr2); end
    @(posedge clk); #1;
    total++;
    if (iaddr2 !== 4'h0) begin bad++; $display("FAIL pc_wrap: iaddr2=%0h want 0", iaddr2); end
    instr2 = 16'h0001; op2 = 3'd1; we32 = 1;                   // r1 = ~r0 = 0xFFFF
    @(posedge clk); #1;
    instr2 = {4'h0, 8'h01, 4'h2}; s_inm2 = 1; op2 = 3'd0;      // r2 = 1
    @(posedge clk); #1;
    instr2 = 16'h0100; s_inm2 = 0; we32 = 0; wez2 = 1;         // z <- (r1 == 0)
    @(posedge clk); #1;
    total++;
    if (z2 !== 1'b0) begin bad++; $display("FAIL wide_ffff: z2=%0b want 0", z2); end
    instr2 = 16'h0120; op2 = 3'd2;                             // r1 + r2
    @(posedge clk); #1;
    total++;
    if (z2 !== 1'b1) begin bad++; $display("FAIL wide_add_wrap: z2=%0b want 1", z2); end
    wez2 = 0; s_inc2 = 0;
  endtask

  initial begin
    reset = 1'b0;
    instr = '0; s_inc = 0; s_inm = 0; we3 = 0; wez = 0; op = '0; s_call = 0; s_ret = 0;
    instr2 = '0; s_inc2 = 0; s_inm2 = 0; we32 = 0; wez2 = 0; op2 = '0;
    for (int k = 0; k < 16; k++) m_regs[k] = 'x;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    test_alu();
    test_reset_midrun();
    test_call_ret();
    test_reset_midrun();
    test_nested();
    test_reset_midrun();
    test_wrap_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
